// File: rtl/para_evt_arb.sv
// rtl/para_evt_arb.sv - round-robin merge of para_hit channel events onto one valid/ready stream
// Optional macro PARA_EVT_TS_EN adds the capture timestamp counter and per-slot ts storage.
module para_evt_arb #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int TSW = 32
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [NCH*16-1:0]    ph_ring,
    input  logic [NCH-1:0]       ph_vld,
    input  logic                 cfg_en,
    input  logic [NCH-1:0]       cfg_ch_mask,
    input  logic                 clr_ovf,
    output logic [15:0]          ev_data,
    output logic [CHW-1:0]       ev_ch,
    output logic [TSW-1:0]       ev_ts,
    output logic                 ev_vld,
    input  logic                 ev_rdy,
    output logic [NCH-1:0]       stu_pend,
    output logic [15:0]          stu_ovf_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CHW-1:0]  last_grant, grant;
    logic [NCH-1:0]  cap, loading, wr, drop;
    logic            load;
    logic [16:0]     ovf_sum;
    logic [15:0]     slot_data [NCH];

    assign ev_vld = (state == HOLD);
    assign load   = ((state == IDLE) || (ev_vld && ev_rdy)) && (|stu_pend);

    // Search starts just after the last winner so every pending channel is served within NCH loads.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_grant) + k) % NCH;
            if (!found && stu_pend[idx]) begin
                grant = CHW'(idx);
                found = 1'b1;
            end
        end
    end

    // A slot being emptied into the output this cycle can take a fresh event without a drop.
    always_comb begin
        ovf_sum = {1'b0, stu_ovf_cnt};
        for (int i = 0; i < NCH; i++) begin
            cap[i]     = ph_vld[i] & cfg_en & cfg_ch_mask[i];
            loading[i] = load && (grant == CHW'(i));
            wr[i]      = cap[i] && (!stu_pend[i] || loading[i]);
            drop[i]    = cap[i] && stu_pend[i] && !loading[i];
            ovf_sum    = ovf_sum + 17'(drop[i]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = HOLD;
            HOLD: if (ev_rdy) state_nxt = load ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= CHW'(NCH - 1);
            ev_data     <= '0;
            ev_ch       <= '0;
            stu_pend    <= '0;
            stu_ovf_cnt <= '0;
            for (int i = 0; i < NCH; i++) slot_data[i] <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                ev_data    <= slot_data[grant];
                ev_ch      <= grant;
                last_grant <= grant;
            end
            for (int i = 0; i < NCH; i++) begin
                if (wr[i]) slot_data[i] <= ph_ring[16*i +: 16];
                stu_pend[i] <= wr[i] | (stu_pend[i] & ~loading[i]);
            end
            if (clr_ovf)
                stu_ovf_cnt <= '0;
            else if (ovf_sum[16])
                stu_ovf_cnt <= 16'hFFFF;
            else
                stu_ovf_cnt <= ovf_sum[15:0];
        end
    end

`ifdef PARA_EVT_TS_EN
    logic [TSW-1:0] ts_cnt;
    logic [TSW-1:0] slot_ts [NCH];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
            ev_ts  <= '0;
            for (int i = 0; i < NCH; i++) slot_ts[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (load) ev_ts <= slot_ts[grant];
            for (int i = 0; i < NCH; i++)
                if (wr[i]) slot_ts[i] <= ts_cnt;
        end
    end
`else
    assign ev_ts = '0;
`endif

endmodule

// File: tb/tb_para_evt_arb.sv
// tb/tb_para_evt_arb.sv - directed self-checking bench for para_evt_arb
module tb_para_evt_arb;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ph_ring = '0;
    logic [3:0]  ph_vld = '0;
    logic        cfg_en = 1'b1;
    logic [3:0]  cfg_ch_mask = 4'hF;
    logic        clr_ovf = 1'b0;
    logic [15:0] ev_data;
    logic [1:0]  ev_ch;
    logic [31:0] ev_ts;
    logic        ev_vld;
    logic        ev_rdy = 1'b0;
    logic [3:0]  stu_pend;
    logic [15:0] stu_ovf_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] tb_cyc;
    logic [31:0] ts_a, ts_b;

    para_evt_arb #(.NCH(4), .CHW(2), .TSW(32)) dut (
        .clk_sys(clk_sys), .rst(rst), .ph_ring(ph_ring), .ph_vld(ph_vld),
        .cfg_en(cfg_en), .cfg_ch_mask(cfg_ch_mask), .clr_ovf(clr_ovf),
        .ev_data(ev_data), .ev_ch(ev_ch), .ev_ts(ev_ts), .ev_vld(ev_vld),
        .ev_rdy(ev_rdy), .stu_pend(stu_pend), .stu_ovf_cnt(stu_ovf_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference cycle count: value the timestamp counter holds during the current cycle.
    always @(posedge clk_sys or posedge rst)
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ts_exp(input logic [31:0] t);
`ifdef PARA_EVT_TS_EN
        return t;
`else
        return 32'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ph_vld = '0; ev_rdy = 1'b0; clr_ovf = 1'b0; cfg_en = 1'b1; cfg_ch_mask = 4'hF;
        @(negedge clk_sys);
        rst = 1'b0;
        step();
    endtask

    task automatic strobe(input int ch, input logic [15:0] v);
        ph_ring[16*ch +: 16] = v;
        ph_vld[ch] = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_vld", ev_vld, 0);
        chk("rst_pend", stu_pend, 0);
        chk("rst_ovf", stu_ovf_cnt, 0);
        chk("rst_data", ev_data, 0);
        do_reset();

        // single event on channel 2
        ev_rdy = 1'b1;
        strobe(2, 16'h1234);
        ts_a = tb_cyc;
        step();
        ph_vld = '0;
        chk("single_pend", stu_pend, 4'b0100);
        chk("single_vld_t1", ev_vld, 0);
        step();
        chk("single_vld", ev_vld, 1);
        chk("single_data", ev_data, 16'h1234);
        chk("single_ch", ev_ch, 2);
        chk("single_ts", ev_ts, ts_exp(ts_a));
        chk("single_pend_clr", stu_pend, 0);
        step();
        chk("single_done", ev_vld, 0);

        // fairness: two rounds of all-channel strobes
        do_reset();
        ev_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) strobe(i, 16'hA000 + 16'(r * 16'h100) + 16'(i));
            step();
            ph_vld = '0;
            chk("fair_pend", stu_pend, 4'hF);
            for (int i = 0; i < 4; i++) begin
                step();
                chk("fair_vld", ev_vld, 1);
                chk("fair_ch", ev_ch, i);
                chk("fair_data", ev_data, 16'hA000 + 16'(r * 16'h100) + 16'(i));
            end
            step();
            chk("fair_idle", ev_vld, 0);
        end

        // backpressure: channel 1 strobes four times while ev_rdy is low
        do_reset();
        strobe(1, 16'h1111); ts_a = tb_cyc; step();
        chk("bp_pend0", stu_pend, 4'b0010);
        strobe(1, 16'h2222); ts_b = tb_cyc; step();
        chk("bp_vld", ev_vld, 1);
        chk("bp_ovf0", stu_ovf_cnt, 0);
        chk("bp_pend1", stu_pend, 4'b0010);
        strobe(1, 16'h3333); step();
        chk("bp_ovf1", stu_ovf_cnt, 1);
        strobe(1, 16'h4444); step();
        ph_vld = '0;
        chk("bp_ovf2", stu_ovf_cnt, 2);
        step(); step();
        chk("bp_hold_vld", ev_vld, 1);
        chk("bp_hold_data", ev_data, 16'h1111);
        chk("bp_hold_ch", ev_ch, 1);
        chk("bp_hold_ts", ev_ts, ts_exp(ts_a));
        ev_rdy = 1'b1;
        step();
        chk("bp_next_data", ev_data, 16'h2222);
        chk("bp_next_ts", ev_ts, ts_exp(ts_b));
        chk("bp_next_vld", ev_vld, 1);
        chk("bp_next_pend", stu_pend, 0);
        step();
        chk("bp_idle", ev_vld, 0);
        chk("bp_ovf_keep", stu_ovf_cnt, 2);

        // same-cycle reload on channel 0
        do_reset();
        strobe(0, 16'h0AAA); step();
        strobe(0, 16'h0BBB); step();
        chk("rl_data0", ev_data, 16'h0AAA);
        chk("rl_pend0", stu_pend, 4'b0001);
        ev_rdy = 1'b1;
        strobe(0, 16'h0CCC); step();
        ph_vld = '0;
        chk("rl_data1", ev_data, 16'h0BBB);
        chk("rl_pend1", stu_pend, 4'b0001);
        chk("rl_ovf", stu_ovf_cnt, 0);
        step();
        chk("rl_data2", ev_data, 16'h0CCC);
        chk("rl_pend2", stu_pend, 0);
        step();
        chk("rl_idle", ev_vld, 0);

        // masking, global disable and overflow clear
        do_reset();
        cfg_ch_mask = 4'b1011;
        strobe(2, 16'h5555); step();
        ph_vld = '0;
        chk("mask_pend", stu_pend, 0);
        chk("mask_ovf", stu_ovf_cnt, 0);
        cfg_ch_mask = 4'hF; cfg_en = 1'b0;
        strobe(3, 16'h6666); step();
        ph_vld = '0;
        chk("dis_pend", stu_pend, 0);
        chk("dis_vld", ev_vld, 0);
        cfg_en = 1'b1;
        strobe(1, 16'h0001); step();
        strobe(1, 16'h0002); step();
        strobe(1, 16'h0003); step();
        chk("clr_pre", stu_ovf_cnt, 1);
        strobe(1, 16'h0004); clr_ovf = 1'b1; step();
        clr_ovf = 1'b0;
        chk("clr_ovf", stu_ovf_cnt, 0);
        strobe(1, 16'h0005); step();
        ph_vld = '0;
        chk("clr_resume", stu_ovf_cnt, 1);

        // saturation, then asynchronous reset while holding
        do_reset();
        for (int i = 0; i < 4; i++) strobe(i, 16'hC000 + 16'(i));
        step(); step();
        chk("sat_first", stu_ovf_cnt, 3);
        for (int n = 0; n < 16400; n++) step();
        chk("sat_ovf", stu_ovf_cnt, 16'hFFFF);
        chk("sat_vld", ev_vld, 1);
        chk("sat_data", ev_data, 16'hC000);
        ph_vld = '0;
        rst = 1'b1;
        #1;
        chk("arst_vld", ev_vld, 0);
        chk("arst_pend", stu_pend, 0);
        chk("arst_ovf", stu_ovf_cnt, 0);
        chk("arst_data", ev_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
